// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter/sequencer sharing one registered ALU
// Define ALU_ARB_FIXED_PRI_EN for fixed port-0 priority instead of round-robin.
module alu_arbiter #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [3:0]        rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [3:0]        rsp1_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_sign,
  input  logic              alu_overflow,
  output logic              busy
);

  localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last_grant;
  logic               r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [OP_W-1:0]    r_alu_op;
  logic               r_rsp0_valid;
  logic               r_rsp1_valid;
  logic [DATA_W-1:0]  r_rsp0_result;
  logic [DATA_W-1:0]  r_rsp1_result;
  logic [3:0]         r_rsp0_flags;
  logic [3:0]         r_rsp1_flags;
  logic               w_sel;
  logic               w_hs;
  logic               w_done;
  logic               w_rsp_hs;
  logic [3:0]         w_flags;

  // Idle selection favours the port not served last; a tie goes the same way
  // unless fixed priority is built in.
  always_comb begin
    w_sel = ~r_last_grant;
    if (req0_valid && !req1_valid) begin
      w_sel = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      w_sel = 1'b1;
    end
`ifdef ALU_ARB_FIXED_PRI_EN
    else if (req0_valid && req1_valid) begin
      w_sel = 1'b0;
    end
`else
`endif
  end

  assign req0_ready = (r_state == S_IDLE) && !w_sel;
  assign req1_ready = (r_state == S_IDLE) && w_sel;
  assign w_hs       = (r_state == S_IDLE) && (w_sel ? req1_valid : req0_valid);
  assign w_done     = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_rsp_hs   = (r_state == S_RESP) && (r_owner ? rsp1_ready : rsp0_ready);
  assign w_flags    = {alu_carry, alu_overflow, alu_sign, alu_zero};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hs)     w_next = S_WAIT;
      S_WAIT:  if (w_done)   w_next = S_RESP;
      S_RESP:  if (w_rsp_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant  <= 1'b1;
      r_owner       <= 1'b0;
      r_cnt         <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_rsp0_valid  <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp1_result <= '0;
      r_rsp0_flags  <= '0;
      r_rsp1_flags  <= '0;
    end else begin
      if (w_hs) begin
        r_owner      <= w_sel;
        r_last_grant <= w_sel;
        r_cnt        <= CNT_W'(ALU_LAT);
        r_alu_a      <= w_sel ? req1_a  : req0_a;
        r_alu_b      <= w_sel ? req1_b  : req0_b;
        r_alu_op     <= w_sel ? req1_op : req0_op;
      end
      if (r_state == S_WAIT && !w_done) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // Result is sampled only in the final WAIT cycle, once the ALU pipeline has filled.
      if (w_done) begin
        if (r_owner) begin
          r_rsp1_valid  <= 1'b1;
          r_rsp1_result <= alu_result;
          r_rsp1_flags  <= w_flags;
        end else begin
          r_rsp0_valid  <= 1'b1;
          r_rsp0_result <= alu_result;
          r_rsp0_flags  <= w_flags;
        end
      end
      if (w_rsp_hs) begin
        if (r_owner) begin
          r_rsp1_valid <= 1'b0;
        end else begin
          r_rsp0_valid <= 1'b0;
        end
      end
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp1_result = r_rsp1_result;
  assign rsp0_flags  = r_rsp0_flags;
  assign rsp1_flags  = r_rsp1_flags;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
// Fixed-priority steps run only when ALU_ARB_FIXED_PRI_EN is defined.
module tb_alu_arbiter;

  localparam int DW = 8;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OW-1:0] req0_op = '0, req1_op = '0;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [DW-1:0] rsp0_result, rsp1_result;
  logic [3:0]    rsp0_flags, rsp1_flags;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [OW-1:0] alu_op;
  logic          alu_carry, alu_zero, alu_sign, alu_overflow;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .OP_W(OW), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_overflow(alu_overflow),
    .busy(busy)
  );

  // One-cycle registered ALU: 0 ADD, 1 SUB (carry = no borrow), 4 XOR, 5 SHL, others AND.
  logic [DW:0]   m_sum;
  logic [DW-1:0] m_res;
  logic          m_c, m_v;
  always_comb begin
    m_sum = '0;
    m_res = '0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (alu_op)
      3'd0: begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b};
        m_res = m_sum[DW-1:0];
        m_c   = m_sum[DW];
        m_v   = (alu_a[DW-1] == alu_b[DW-1]) && (m_res[DW-1] != alu_a[DW-1]);
      end
      3'd1: begin
        m_res = alu_a - alu_b;
        m_c   = (alu_a >= alu_b);
        m_v   = (alu_a[DW-1] != alu_b[DW-1]) && (m_res[DW-1] != alu_a[DW-1]);
      end
      3'd4: m_res = alu_a ^ alu_b;
      3'd5: begin
        m_res = {alu_a[DW-2:0], 1'b0};
        m_c   = alu_a[DW-1];
      end
      default: m_res = alu_a & alu_b;
    endcase
  end

  always_ff @(posedge clk) begin
    alu_result   <= m_res;
    alu_carry    <= m_c;
    alu_overflow <= m_v;
    alu_sign     <= m_res[DW-1];
    alu_zero     <= (m_res == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_op", alu_op, 3'd0);
    chk("rst_rsp0_result", rsp0_result, 8'h00);
    chk("idle_default_req0_ready", req0_ready, 1'b1);
    chk("idle_default_req1_ready", req1_ready, 1'b0);

    // Port 0 ADD 0x7F + 0x01
    req0_a = 8'h7F; req0_b = 8'h01; req0_op = 3'd0; req0_valid = 1'b1; rsp0_ready = 1'b1;
    #1;
    chk("add_req0_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    chk("add_t1_busy", busy, 1'b1);
    chk("add_t1_alu_a", alu_a, 8'h7F);
    chk("add_t1_alu_b", alu_b, 8'h01);
    chk("add_t1_req0_ready", req0_ready, 1'b0);
    chk("add_t1_rsp0_valid", rsp0_valid, 1'b0);
    tick();
    chk("add_t2_rsp0_valid", rsp0_valid, 1'b0);
    tick();
    chk("add_t3_rsp0_valid", rsp0_valid, 1'b1);
    chk("add_result", rsp0_result, 8'h80);
    chk("add_flags", rsp0_flags, 4'b0110);
    chk("add_rsp1_valid", rsp1_valid, 1'b0);
    tick();
    chk("add_t4_rsp0_valid", rsp0_valid, 1'b0);
    chk("add_t4_busy", busy, 1'b0);

    // Simultaneous requests alternate 0,1,0,1 from reset
    pulse_reset();
    req0_a = 8'h05; req0_b = 8'h05; req0_op = 3'd1;
    req1_a = 8'hAA; req1_b = 8'hFF; req1_op = 3'd4;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant0", req0_ready, (i % 2) == 0);
      chk("rr_grant1", req1_ready, (i % 2) == 1);
      tick();
      tick();
      tick();
      if ((i % 2) == 0) begin
        chk("rr_sub_valid", rsp0_valid, 1'b1);
        chk("rr_sub_result", rsp0_result, 8'h00);
        chk("rr_sub_flags", rsp0_flags, 4'b1001);
        chk("rr_sub_other", rsp1_valid, 1'b0);
      end else begin
        chk("rr_xor_valid", rsp1_valid, 1'b1);
        chk("rr_xor_result", rsp1_result, 8'h55);
        chk("rr_xor_flags", rsp1_flags, 4'b0000);
        chk("rr_xor_other", rsp0_valid, 1'b0);
      end
      tick();
    end

    // Port 1 response back-pressured for 5 cycles while port 0 waits
    req0_valid = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk("bp_req1_ready", req1_ready, 1'b1);
    tick();
    req0_valid = 1'b1;
    #1;
    chk("bp_wait_req0_ready", req0_ready, 1'b0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp1_valid", rsp1_valid, 1'b1);
      chk("bp_rsp1_result", rsp1_result, 8'h55);
      chk("bp_rsp1_flags", rsp1_flags, 4'b0000);
      chk("bp_req0_ready", req0_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
      if (k < 4) tick();
    end
    rsp1_ready = 1'b1;
    #1;
    chk("bp_release_valid", rsp1_valid, 1'b1);
    tick();
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_idle_rsp1_valid", rsp1_valid, 1'b0);
    chk("bp_idle_req0_ready", req0_ready, 1'b1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset during WAIT of port 0 SHL 0x81
    req0_a = 8'h81; req0_b = 8'h00; req0_op = 3'd5; req0_valid = 1'b1;
    #1;
    chk("shl_req0_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    chk("shl_wait_busy", busy, 1'b1);
    chk("shl_wait_alu_a", alu_a, 8'h81);
    chk("shl_wait_alu_op", alu_op, 3'd5);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_alu_a", alu_a, 8'h00);
    chk("arst_alu_b", alu_b, 8'h00);
    chk("arst_alu_op", alu_op, 3'd0);
    chk("arst_rsp0_valid", rsp0_valid, 1'b0);
    chk("arst_rsp1_result", rsp1_result, 8'h00);
    chk("arst_rsp1_flags", rsp1_flags, 4'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("arst_no_rsp0", rsp0_valid, 1'b0);
      chk("arst_idle", busy, 1'b0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("arst_tie_req0_ready", req0_ready, 1'b1);
    chk("arst_tie_req1_ready", req1_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;

`ifdef ALU_ARB_FIXED_PRI_EN
    pulse_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("fp_req0_ready", req0_ready, 1'b1);
      chk("fp_req1_ready", req1_ready, 1'b0);
      tick();
      tick();
      tick();
      chk("fp_rsp0_valid", rsp0_valid, 1'b1);
      tick();
    end
    req0_valid = 1'b0;
    #1;
    chk("fp_req1_after_drop", req1_ready, 1'b1);
    req1_valid = 1'b0;
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares a single registered 8-bit ALU instance between two requesters. Each requester submits `{A, B, op}` over a valid/ready handshake. The block grants one request at a time, holds the operands on the ALU inputs for the ALU's pipeline latency, and captures the result and flags. It then returns them to the issuing requester over a per-port response handshake. It sits between the datapath clients and the ALU in the top-level design.

## Interface
Parameters:
- `DATA_W`, 8: operand and result width.
- `OP_W`, 3: opcode width.
- `ALU_LAT`, 1: cycles from ALU inputs being stable to the registered ALU result being visible; must be ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when paired with valid.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  DATA_W  operands.
- `req0_op`, `req1_op`  in  OP_W  ALU opcode, passed through unmodified.
- `rsp0_valid`, `rsp1_valid`  out  1  response present.
- `rsp0_ready`, `rsp1_ready`  in  1  response consumed.
- `rsp0_result`, `rsp1_result`  out  DATA_W  ALU result.
- `rsp0_flags`, `rsp1_flags`  out  4  {carry, overflow, sign, zero}.
- `alu_a`, `alu_b`  out  DATA_W  to ALU.
- `alu_op`  out  OP_W  to ALU.
- `alu_result`  in  DATA_W  from ALU.
- `alu_carry`, `alu_zero`, `alu_sign`, `alu_overflow`  in  1  from ALU.
- `busy`  out  1  high in any state other than IDLE.

## Operation
State machine: IDLE → WAIT → RESP → IDLE.
- **IDLE**
  - `reqN_ready` = 1 only for the requester selected by arbitration; the other port's ready = 0.
  - Selection: if only one port is valid, it is selected. If both are valid, the port not served last is selected (round-robin; `last_grant` register).
  - With no valid request, the selection defaults to the port favoured by `last_grant`. A ready on that port with valid low has no effect.
  - On handshake, the block:
    - captures A/B/op into operand registers;
    - records the owner port ID;
    - updates `last_grant`;
    - loads the wait counter with ALU_LAT;
    - moves to WAIT.
- **WAIT**
  - `alu_a`/`alu_b`/`alu_op` drive the captured operands. They stay stable until the next grant, and are 0 after reset.
  - The counter decrements each cycle. In the WAIT cycle where the counter is 0, the block samples `alu_result` and the flags into response registers and moves to RESP. WAIT therefore lasts ALU_LAT+1 cycles.
  - Both `reqN_ready` are 0.
- **RESP**
  - `rspN_valid` = 1 for the owner port only. Result and flags are held stable while valid.
  - When `rspN_ready` = 1, the block returns to IDLE. No new request is accepted in the same cycle.
  - The non-owner `rsp_valid` stays 0.
- Flags are passed through unmodified, including the ALU's SUB carry convention (1 = no borrow).

## Timing
- Reset values:
  - `state` = IDLE, `last_grant` = 1 (port 0 wins the first tie).
  - All `rsp*_valid`, `rsp*_result`, `rsp*_flags` = 0.
  - `alu_a`, `alu_b`, `alu_op` = 0.
  - `busy` = 0.
- `reqN_ready` is combinational from state, valids and `last_grant`; `rspN_valid` is registered.
- With a request handshake in cycle T, `rsp_valid` rises in cycle T+2+ALU_LAT (T+3 at the default).
- Minimum issue interval is ALU_LAT+3 cycles, reached when `rsp_ready` is held high.
- Boundary conditions:
  - `rst` asserted mid-WAIT or mid-RESP: the transaction is discarded, no response is ever produced, and the state returns to IDLE immediately (asynchronously).
  - Requests arriving during WAIT or RESP are held off (ready = 0). They must stay valid and stable per the handshake rules.
  - Back-to-back simultaneous requests alternate 0,1,0,1…
  - The ALU's own synchronous reset is the integrator's responsibility. It is not driven from this block.

## Configuration
- `ALU_ARB_FIXED_PRI_EN`
  - Defined: port 0 always wins when both ports are valid, and `last_grant` is not used for selection. Port 1 can starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Port 0 requests ADD A=0x7F B=0x01 with `rsp0_ready`=1: `rsp0_valid` at T+3 with result 0x80, flags {c=0, v=1, s=1, z=0}; `rsp1_valid` stays 0 throughout.
- Both ports valid continuously (port 0 SUB 0x05−0x05, port 1 XOR 0xAA^0xFF): grants go 0,1,0,1.
  - Port 0 responses: result 0x00, flags {1,0,0,1}.
  - Port 1 responses: result 0x55, flags {0,0,0,0}.
- `rsp1_ready` held 0 for 5 cycles after `rsp1_valid`: response stays stable, `req0_ready` = 0 and `busy` = 1 throughout. Return to IDLE occurs the cycle after ready rises.
- `rst` pulsed during WAIT of a port 0 SHL 0x81: no `rsp0_valid`, all outputs at their reset values. The next simultaneous request is granted to port 0.
- With `ALU_ARB_FIXED_PRI_EN` defined and both ports valid for 3 transactions: all three are granted to port 0. Port 1 is granted only after `req0_valid` drops.
